mem_port_arbiter: RTL and testbench

Shares one Avalon-MM memory port between the CPU's instruction fetch bus (read-only) and data bus (read/write). The block sits between the CPU core and the single-ported system memory. It grants the port to one requester at a time, holds ownership until the transfer completes, and routes `readdatavalid` only to the owner. At most one transfer is outstanding; reads are not pipelined.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction, data and memory-side Avalon-MM signals around mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the CPU/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   i_address;
  logic                i_read;
  logic [DATA_W-1:0]   i_readdata;
  logic                i_readdatavalid;
  logic                i_waitrequest;

  logic [ADDR_W-1:0]   d_address;
  logic                d_read;
  logic                d_write;
  logic [DATA_W/8-1:0] d_byteenable;
  logic [DATA_W-1:0]   d_writedata;
  logic [DATA_W-1:0]   d_readdata;
  logic                d_readdatavalid;
  logic                d_waitrequest;

  logic [ADDR_W-1:0]   m_address;
  logic                m_read;
  logic                m_write;
  logic [DATA_W/8-1:0] m_byteenable;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W-1:0]   m_readdata;
  logic                m_readdatavalid;
  logic                m_waitrequest;

  modport slave (
    input  i_address, i_read,
    output i_readdata, i_readdatavalid, i_waitrequest,
    input  d_address, d_read, d_write, d_byteenable, d_writedata,
    output d_readdata, d_readdatavalid, d_waitrequest,
    output m_address, m_read, m_write, m_byteenable, m_writedata,
    input  m_readdata, m_readdatavalid, m_waitrequest
  );

  modport master (
    output i_address, i_read,
    input  i_readdata, i_readdatavalid, i_waitrequest,
    output d_address, d_read, d_write, d_byteenable, d_writedata,
    input  d_readdata, d_readdatavalid, d_waitrequest,
    input  m_address, m_read, m_write, m_byteenable, m_writedata,
    output m_readdata, m_readdatavalid, m_waitrequest
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-MM memory port between instruction fetch and data buses, one transfer at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on conflicts; default is fixed data-over-instruction.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, WAIT_RD} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;

  logic              req_i, req_d, d_wins;
  logic [ADDR_W-1:0] m_address_c;
  logic              m_read_c, m_write_c;
  logic [BE_W-1:0]   m_byteenable_c;
  logic [DATA_W-1:0] m_writedata_c;
  logic              i_waitrequest_c, d_waitrequest_c;
  logic              i_readdatavalid_c, d_readdatavalid_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_q, last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= OWN_I;
    else      last_q <= last_d;
  end

  assign d_wins = (last_q == OWN_I);
`else
  assign d_wins = 1'b1;
`endif

  assign req_i = bus.i_read;
  assign req_d = bus.d_read | bus.d_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d            = last_q;
`endif
    m_address_c       = '0;
    m_read_c          = 1'b0;
    m_write_c         = 1'b0;
    m_byteenable_c    = '0;
    m_writedata_c     = '0;
    i_waitrequest_c   = 1'b1;
    d_waitrequest_c   = 1'b1;
    i_readdatavalid_c = 1'b0;
    d_readdatavalid_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i || req_d) begin
          if (req_d && (!req_i || d_wins)) begin
            state_d = GRANT_D;
            owner_d = OWN_D;
          end else begin
            state_d = GRANT_I;
            owner_d = OWN_I;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d = owner_d;
`endif
        end
      end

      GRANT_I: begin
        m_address_c     = bus.i_address;
        m_read_c        = bus.i_read;
        m_byteenable_c  = '1;
        i_waitrequest_c = bus.m_waitrequest;
        if (!bus.i_read)              state_d = IDLE;
        else if (!bus.m_waitrequest)  state_d = WAIT_RD;
      end

      GRANT_D: begin
        // Simultaneous read and write from the data bus is issued as a write.
        m_address_c     = bus.d_address;
        m_write_c       = bus.d_write;
        m_read_c        = bus.d_read & ~bus.d_write;
        m_byteenable_c  = bus.d_byteenable;
        m_writedata_c   = bus.d_writedata;
        d_waitrequest_c = bus.m_waitrequest;
        if (!req_d)                   state_d = IDLE;
        else if (!bus.m_waitrequest)  state_d = bus.d_write ? IDLE : WAIT_RD;
      end

      WAIT_RD: begin
        if (bus.m_readdatavalid) begin
          if (owner_q == OWN_D) d_readdatavalid_c = 1'b1;
          else                  i_readdatavalid_c = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.m_address       = m_address_c;
  assign bus.m_read          = m_read_c;
  assign bus.m_write         = m_write_c;
  assign bus.m_byteenable    = m_byteenable_c;
  assign bus.m_writedata     = m_writedata_c;
  assign bus.i_waitrequest   = i_waitrequest_c;
  assign bus.d_waitrequest   = d_waitrequest_c;
  assign bus.i_readdatavalid = i_readdatavalid_c;
  assign bus.d_readdatavalid = d_readdatavalid_c;
  assign bus.i_readdata      = bus.m_readdata;
  assign bus.d_readdata      = bus.m_readdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expected grant order follows MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;
  bit   exp_d [4];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif

    // Reset with both sides requesting and a stray readdatavalid
    rst                 = 1'b0;
    bus.i_address       = 32'h0;
    bus.i_read          = 1'b1;
    bus.d_address       = 32'h0;
    bus.d_read          = 1'b1;
    bus.d_write         = 1'b1;
    bus.d_byteenable    = 4'hF;
    bus.d_writedata     = 32'h0;
    bus.m_readdata      = 32'h0;
    bus.m_readdatavalid = 1'b1;
    bus.m_waitrequest   = 1'b0;
    mid();
    chk("rst_m_read", bus.m_read, 1'b0);
    chk("rst_m_write", bus.m_write, 1'b0);
    chk("rst_m_address", bus.m_address, 32'h0);
    chk("rst_m_byteenable", bus.m_byteenable, 4'h0);
    chk("rst_i_waitrequest", bus.i_waitrequest, 1'b1);
    chk("rst_d_waitrequest", bus.d_waitrequest, 1'b1);
    chk("rst_i_rdv", bus.i_readdatavalid, 1'b0);
    chk("rst_d_rdv", bus.d_readdatavalid, 1'b0);
    tick();
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.m_readdatavalid = 1'b0;
    rst = 1'b1;
    tick();

    // Lone fetch
    bus.i_address = 32'h100;
    bus.i_read    = 1'b1;
    mid();
    chk("fetch_idle_m_read", bus.m_read, 1'b0);
    chk("fetch_idle_i_wait", bus.i_waitrequest, 1'b1);
    tick();
    mid();
    chk("fetch_m_read", bus.m_read, 1'b1);
    chk("fetch_m_address", bus.m_address, 32'h100);
    chk("fetch_m_byteenable", bus.m_byteenable, 4'hF);
    chk("fetch_i_wait", bus.i_waitrequest, 1'b0);
    chk("fetch_d_wait", bus.d_waitrequest, 1'b1);
    tick();
    bus.i_read          = 1'b0;
    bus.m_readdata      = 32'h0000_0013;
    bus.m_readdatavalid = 1'b1;
    mid();
    chk("fetch_wait_m_read", bus.m_read, 1'b0);
    chk("fetch_i_rdv", bus.i_readdatavalid, 1'b1);
    chk("fetch_i_readdata", bus.i_readdata, 32'h13);
    chk("fetch_d_rdv", bus.d_readdatavalid, 1'b0);
    tick();
    bus.m_readdatavalid = 1'b1;
    mid();
    chk("idle_rdv_ignored_i", bus.i_readdatavalid, 1'b0);
    chk("idle_rdv_ignored_d", bus.d_readdatavalid, 1'b0);
    tick();
    bus.m_readdatavalid = 1'b0;

    // Conflict: data write wins, fetch follows after one IDLE cycle
    bus.i_address    = 32'h200;
    bus.i_read       = 1'b1;
    bus.d_address    = 32'h1000;
    bus.d_write      = 1'b1;
    bus.d_writedata  = 32'hDEAD_BEEF;
    bus.d_byteenable = 4'h3;
    tick();
    mid();
    chk("conf_m_write", bus.m_write, 1'b1);
    chk("conf_m_read", bus.m_read, 1'b0);
    chk("conf_m_address", bus.m_address, 32'h1000);
    chk("conf_m_writedata", bus.m_writedata, 32'hDEAD_BEEF);
    chk("conf_m_byteenable", bus.m_byteenable, 4'h3);
    chk("conf_d_wait", bus.d_waitrequest, 1'b0);
    chk("conf_i_wait", bus.i_waitrequest, 1'b1);
    tick();
    bus.d_write = 1'b0;
    mid();
    chk("conf_gap_m_write", bus.m_write, 1'b0);
    chk("conf_gap_m_read", bus.m_read, 1'b0);
    chk("conf_gap_i_wait", bus.i_waitrequest, 1'b1);
    tick();
    mid();
    chk("conf_rd_m_read", bus.m_read, 1'b1);
    chk("conf_rd_m_address", bus.m_address, 32'h200);
    chk("conf_rd_m_byteenable", bus.m_byteenable, 4'hF);
    tick();
    bus.i_read          = 1'b0;
    bus.m_readdata      = 32'h0000_0055;
    bus.m_readdatavalid = 1'b1;
    mid();
    chk("conf_i_rdv", bus.i_readdatavalid, 1'b1);
    tick();
    bus.m_readdatavalid = 1'b0;

    // Sustained conflict over four transfers
    bus.i_read       = 1'b1;
    bus.d_write      = 1'b1;
    bus.d_byteenable = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      mid();
      chk($sformatf("sust%0d_m_write", k), bus.m_write, exp_d[k]);
      chk($sformatf("sust%0d_m_read", k), bus.m_read, !exp_d[k]);
      if (!exp_d[k]) begin
        tick();
        bus.m_readdatavalid = 1'b1;
        mid();
        chk($sformatf("sust%0d_i_rdv", k), bus.i_readdatavalid, 1'b1);
        tick();
        bus.m_readdatavalid = 1'b0;
      end else begin
        tick();
      end
    end
    bus.i_read  = 1'b0;
    bus.d_write = 1'b0;
    tick();

    // Memory stall on a data read
    bus.d_address     = 32'h40;
    bus.d_read        = 1'b1;
    bus.m_waitrequest = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      mid();
      chk($sformatf("stall%0d_m_read", k), bus.m_read, 1'b1);
      chk($sformatf("stall%0d_m_address", k), bus.m_address, 32'h40);
      chk($sformatf("stall%0d_d_wait", k), bus.d_waitrequest, 1'b1);
      tick();
    end
    bus.m_waitrequest = 1'b0;
    mid();
    chk("stall_accept_d_wait", bus.d_waitrequest, 1'b0);
    chk("stall_accept_m_read", bus.m_read, 1'b1);
    tick();
    bus.d_read          = 1'b0;
    bus.m_readdata      = 32'hCAFE_0040;
    bus.m_readdatavalid = 1'b1;
    mid();
    chk("stall_wait_d_wait", bus.d_waitrequest, 1'b1);
    chk("stall_d_rdv", bus.d_readdatavalid, 1'b1);
    chk("stall_i_rdv", bus.i_readdatavalid, 1'b0);
    chk("stall_d_readdata", bus.d_readdata, 32'hCAFE_0040);
    tick();
    bus.m_readdatavalid = 1'b0;

    // Reset while waiting for read data, then late readdatavalid
    bus.i_address = 32'h300;
    bus.i_read    = 1'b1;
    tick();
    tick();
    bus.i_read = 1'b0;
    #2;
    rst = 1'b0;
    bus.m_readdatavalid = 1'b1;
    #1;
    chk("rstwait_i_rdv", bus.i_readdatavalid, 1'b0);
    chk("rstwait_m_read", bus.m_read, 1'b0);
    tick();
    rst = 1'b1;
    mid();
    chk("late_i_rdv", bus.i_readdatavalid, 1'b0);
    chk("late_d_rdv", bus.d_readdatavalid, 1'b0);
    tick();
    bus.m_readdatavalid = 1'b0;
    bus.d_address = 32'h80;
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    tick();
    mid();
    chk("post_rst_rw_m_write", bus.m_write, 1'b1);
    chk("post_rst_rw_m_read", bus.m_read, 1'b0);
    chk("post_rst_m_address", bus.m_address, 32'h80);
    tick();
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    mid();
    chk("post_rst_idle_m_write", bus.m_write, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
